fetch_line_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decode stage.
- Issues line-sized (64-byte) read requests on the system bus and collects the 8 response beats into a line buffer.
- Delivers 32-bit instructions to decode, one per handshake, in program order; handles redirects and halts on a zero instruction word.

---
 rtl/fetch_line_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_line_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_unit.sv
// Line-based instruction fetch front end: fills a 64-byte line from the bus
// and hands 32-bit words to decode in program order.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

module fetch_line_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      out_valid,
  output logic [31:0]               out_instr,
  output logic [63:0]               out_pc,
  input  logic                      out_ready,
  output logic                      halted
);

  localparam int LW = LINE_BEATS * BUS_DATA_WIDTH;
  localparam int CW = $clog2(LINE_BEATS);
  localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] TAG =
    BUS_TAG_WIDTH'({1'b1, `SYSBUS_MEMORY, 8'h00});

  typedef enum logic [2:0] {
    REQ, RESP, DRAIN, DISCARD, HALT
  } state_t;

  state_t        state, state_n;
  logic [63:0]   pc, pc_n;
  logic [63:0]   hold, hold_n;
  logic          pend, pend_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] line;
  logic [63:0]   rpc;
  logic [63:0]   pc_line;
  logic [31:0]   slot;
  logic          beat;
  logic          xfer;

  logic unused_bits;
  assign unused_bits = ^{bus_resptag, redirect_pc[1:0]};

  assign rpc     = {redirect_pc[63:2], 2'b00};
  assign pc_line = {pc[63:6], 6'b0};
  assign slot    = line[pc[5:2]*32 +: 32];

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    hold_n      = hold;
    pend_n      = pend;
    cnt_n       = cnt;
    beat        = 1'b0;
    xfer        = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    out_valid   = 1'b0;
    out_instr   = '0;
    out_pc      = '0;
    halted      = 1'b0;
    if (!reset) begin
      unique case (state)
        REQ: begin
          bus_reqcyc = 1'b1;
          // once a redirect is pending the issued address is frozen in hold
          bus_req    = BUS_DATA_WIDTH'(pend ? hold : pc_line);
          bus_reqtag = TAG;
          if (redirect_valid) pc_n = rpc;
          if (bus_reqack) begin
            state_n = (pend || redirect_valid) ? DISCARD : RESP;
            pend_n  = 1'b0;
          end else if (redirect_valid) begin
            pend_n = 1'b1;
            if (!pend) hold_n = pc_line;
          end
        end
        RESP, DISCARD: begin
          bus_respack = bus_respcyc;
          beat        = bus_respcyc;
          if (beat) cnt_n = cnt + 1'b1;
          if (redirect_valid) begin
            pc_n    = rpc;
            state_n = DISCARD;
          end
          if (beat && cnt == LAST) begin
            cnt_n   = '0;
            state_n = (state == RESP && !redirect_valid) ? DRAIN : REQ;
          end
        end
        DRAIN: begin
          out_instr = slot;
          out_pc    = pc;
          out_valid = (slot != 32'h0);
          xfer      = out_valid && out_ready;
          if (redirect_valid) begin
            pc_n    = rpc;
            state_n = REQ;
          end else if (slot == 32'h0) begin
            state_n = HALT;
          end else if (xfer) begin
            pc_n = pc + 64'd4;
            if (pc[5:2] == 4'hf) state_n = REQ;
          end
        end
        HALT: begin
          halted = 1'b1;
          if (redirect_valid) begin
            pc_n    = rpc;
            state_n = REQ;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc    <= entry;
      hold  <= '0;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (beat && state == RESP)
      line[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
  end

endmodule

// File: tb/tb_fetch_line_unit.sv
// Directed bench for fetch_line_unit: bus responder model, decode-side
// monitor, table of entry vectors and hand-built redirect/halt sequences.
module tb_fetch_line_unit;

  logic        clk;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        halted;

  fetch_line_unit dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .halted(halted)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } cap_t;

  typedef struct {
    logic [63:0] entry;
    bit          tog;
    logic [63:0] req0;
    int          n;
    logic [63:0] req1;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          ack_dly = 0;
  bit          tog = 0;
  bit          zero_en = 0;
  logic [63:0] zero_addr = '0;
  logic [63:0] reqs[$];
  logic [12:0] tags[$];
  cap_t        got[$];
  vec_t        vt[5];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input logic [63:0] a);
    if (zero_en && a == zero_addr) return 32'h0;
    return {8'hA5, a[23:0]};
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] a,
                                            input int k);
    logic [63:0] b;
    b = a + 64'(8 * k);
    return {w(b + 64'd4), w(b)};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // bus slave: acks after ack_dly cycles, then streams 8 beats
  initial begin
    logic [63:0] a;
    bit ab;
    bus_reqack  = 0;
    bus_respcyc = 0;
    bus_resp    = '0;
    bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus_reqcyc) begin
        a  = bus_req;
        ab = 0;
        for (int d = 0; d < ack_dly && !ab; d++) begin
          @(negedge clk);
          if (reset) ab = 1;
          else chk("req_stable", {bus_reqcyc, bus_req}, {1'b1, a});
        end
        if (!ab) begin
          bus_reqack = 1;
          reqs.push_back(a);
          tags.push_back(bus_reqtag);
          @(negedge clk);
          bus_reqack = 0;
          for (int k = 0; k < 8 && !ab; k++) begin
            if (reset) begin
              ab = 1;
            end else begin
              bus_respcyc = 1;
              bus_resp    = beat_data(a, k);
              #1;
              chk("respack", bus_respack, 1);
              @(negedge clk);
            end
          end
        end
        bus_reqack  = 0;
        bus_respcyc = 0;
      end
    end
  end

  // decode side: ready pattern, capture, stall-hold check
  initial begin
    bit          stall;
    logic [63:0] spc;
    logic [31:0] sins;
    out_ready = 1;
    stall     = 0;
    spc       = '0;
    sins      = '0;
    forever begin
      @(negedge clk);
      if (stall && !reset) begin
        chk("hold_pc", out_pc, spc);
        chk("hold_ins", {out_valid, out_instr}, {1'b1, sins});
      end
      out_ready = tog ? ~out_ready : 1'b1;
      stall = out_valid && !out_ready && !reset;
      spc   = out_pc;
      sins  = out_instr;
      if (out_valid && out_ready && !reset)
        got.push_back('{out_pc, out_instr});
    end
  end

  task automatic do_reset(input logic [63:0] e);
    reset = 1;
    entry = e;
    step();
    chk("reset_out", {bus_reqcyc, bus_respack, out_valid, halted,
                      |out_pc, |bus_req, |out_instr, |bus_reqtag}, 0);
    step();
    reqs.delete();
    tags.delete();
    got.delete();
    reset = 0;
  endtask

  task automatic wait_reqs(input int n);
    for (int i = 0; i < 400 && reqs.size() < n; i++) step();
    if (reqs.size() < n) chk("req_timeout", reqs.size(), n);
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 400 && got.size() < n; i++) step();
    if (got.size() < n) chk("instr_timeout", got.size(), n);
  endtask

  task automatic redir(input logic [63:0] p);
    redirect_valid = 1;
    redirect_pc    = p;
    step();
    redirect_valid = 0;
  endtask

  initial begin
    int n;
    int pcyc;
    int hcyc;
    reset          = 1;
    entry          = '0;
    redirect_valid = 0;
    redirect_pc    = '0;

    vt[0] = '{64'h1000, 0, 64'h1000, 16, 64'h1040};
    vt[1] = '{64'h1038, 0, 64'h1000, 2, 64'h1040};
    vt[2] = '{64'h1000, 1, 64'h1000, 16, 64'h1040};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 0, 64'hFFFF_FFFF_FFFF_FFC0, 16,
              64'h0};
    vt[4] = '{64'h7FFC, 1, 64'h7FC0, 1, 64'h8000};

    for (int v = 0; v < 5; v++) begin
      tog = vt[v].tog;
      do_reset(vt[v].entry);
      wait_reqs(2);
      n = got.size();
      chk("instr_count", n, vt[v].n);
      if (reqs.size() >= 2) begin
        chk("req0_addr", reqs[0], vt[v].req0);
        chk("req0_tag", tags[0], 13'h1100);
        chk("req1_addr", reqs[1], vt[v].req1);
      end
      for (int j = 0; j < n && j < vt[v].n; j++) begin
        chk("out_pc", got[j].pc, vt[v].entry + 64'(4 * j));
        chk("out_instr", got[j].ins, w(vt[v].entry + 64'(4 * j)));
      end
    end
    tog = 0;

    // zero word in slot 3 halts fetch
    zero_en   = 1;
    zero_addr = 64'h100C;
    do_reset(64'h1000);
    pcyc = -1;
    hcyc = -1;
    for (int i = 0; i < 200 && hcyc < 0; i++) begin
      step();
      if (halted) hcyc = i;
      else if (!out_valid && out_pc == 64'h100C && pcyc < 0) pcyc = i;
    end
    chk("halt_delay", hcyc - pcyc, 1);
    chk("halt_count", got.size(), 3);
    if (got.size() >= 3) chk("halt_last_pc", got[2].pc, 64'h1008);
    repeat (20) step();
    chk("halt_noreq", reqs.size(), 1);
    chk("halt_idle", {bus_reqcyc, halted, out_valid}, 3'b010);
    redir(64'h4000);
    wait_reqs(2);
    if (reqs.size() >= 2) chk("halt_exit_req", reqs[1], 64'h4000);
    zero_en = 0;

    // redirect after 3 accepted beats
    do_reset(64'h1000);
    wait_reqs(1);
    repeat (3) step();
    redir(64'h2007);
    wait_reqs(2);
    chk("resp_redir_drop", got.size(), 0);
    if (reqs.size() >= 2) chk("resp_redir_req", reqs[1], 64'h2000);
    wait_got(1);
    if (got.size() >= 1) begin
      chk("resp_redir_pc", got[0].pc, 64'h2004);
      chk("resp_redir_ins", got[0].ins, w(64'h2004));
    end

    // delayed ack with two redirects before it; last one wins
    ack_dly = 5;
    do_reset(64'h1000);
    for (int i = 0; i < 20 && !bus_reqcyc; i++) step();
    step();
    redir(64'h5000);
    redir(64'h3000);
    wait_reqs(2);
    ack_dly = 0;
    chk("req_redir_drop", got.size(), 0);
    if (reqs.size() >= 2) begin
      chk("req_redir_old", reqs[0], 64'h1000);
      chk("req_redir_new", reqs[1], 64'h3000);
    end
    wait_got(1);
    if (got.size() >= 1) chk("req_redir_pc", got[0].pc, 64'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
